// File: rtl/mips_seq_pkg.sv
// Shared types and instruction-field constants for the miniMips instruction sequencer.
package mips_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_HALT   = 3'd4
  } seqState_e;

  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [3:0] OP_JMP  = 4'hE;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int JT_MSB  = 11;
  localparam int JT_LSB  = 0;

  function automatic logic [3:0] opcodeOf(input logic [15:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [11:0] jumpField(input logic [15:0] word);
    return word[JT_MSB:JT_LSB];
  endfunction

endpackage

// File: rtl/mips_seq_if.sv
// Instruction-memory fetch handshake between the sequencer (master) and the memory (slave).
interface mips_seq_if #(
  parameter int PC_W = 12
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [15:0]     imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/mips_seq_retire_ctr.sv
// Free-running 32-bit count of retired instructions; cleared when execution (re)starts.
module mips_seq_retire_ctr (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [31:0] count
);

  // Counter register, wraps naturally at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 32'd0;
    end else if (clr) begin
      count <= 32'd0;
    end else if (inc) begin
      count <= count + 32'd1;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/mips_sequencer.sv
// Multi-cycle fetch/execute/commit sequencer driving the miniMips instruction input.
// Optional retired-instruction counter enabled by MIPS_SEQ_RETIRE_CNT_EN.
module mips_sequencer
  import mips_seq_pkg::*;
#(
  parameter int PC_W        = 12,
  parameter int EXEC_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [PC_W-1:0] boot_pc,
  input  logic            stop,
  mips_seq_if.master      imem,
  output logic [15:0]     instr,
  output logic            instr_valid,
  output logic            commit,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted
`ifdef MIPS_SEQ_RETIRE_CNT_EN
  ,
  output logic [31:0]     retired
`endif
);

  localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

  seqState_e       stateR, nextStateS;
  logic [PC_W-1:0] pcR, pcNextS;
  logic [15:0]     irR, irNextS;
  logic [3:0]      cntR, cntNextS;
  logic            stopPendR, stopPendNextS;
  logic            isJmpS;
  logic [PC_W-1:0] jmpTargetS;

  assign isJmpS     = (opcodeOf(irR) == OP_JMP);
  assign jmpTargetS = PC_W'(jumpField(irR));

  // State, PC, IR, execute counter and pending-stop registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateR    <= ST_IDLE;
      pcR       <= {PC_W{1'b0}};
      irR       <= 16'h0000;
      cntR      <= 4'd0;
      stopPendR <= 1'b0;
    end else begin
      stateR    <= nextStateS;
      pcR       <= pcNextS;
      irR       <= irNextS;
      cntR      <= cntNextS;
      stopPendR <= stopPendNextS;
    end
  end

  // Next-state and datapath-register update logic
  always_comb begin
    nextStateS    = stateR;
    pcNextS       = pcR;
    irNextS       = irR;
    cntNextS      = cntR;
    stopPendNextS = stopPendR;
    case (stateR)
      ST_IDLE, ST_HALT: begin
        // start outranks a simultaneous stop, which is simply dropped
        if (start) begin
          nextStateS    = ST_FETCH;
          pcNextS       = boot_pc;
          stopPendNextS = 1'b0;
        end else begin
          nextStateS = stateR;
        end
      end
      ST_FETCH: begin
        if (stop) begin
          stopPendNextS = 1'b1;
        end else begin
          stopPendNextS = stopPendR;
        end
        if (imem.imem_ack) begin
          irNextS = imem.imem_rdata;
          if (opcodeOf(imem.imem_rdata) == OP_HALT) begin
            nextStateS = ST_HALT;
          end else begin
            cntNextS   = EXEC_LOAD;
            nextStateS = ST_EXEC;
          end
        end else begin
          nextStateS = ST_FETCH;
        end
      end
      ST_EXEC: begin
        if (stop) begin
          stopPendNextS = 1'b1;
        end else begin
          stopPendNextS = stopPendR;
        end
        if (cntR == 4'd0) begin
          nextStateS = ST_COMMIT;
        end else begin
          cntNextS = cntR - 4'd1;
        end
      end
      ST_COMMIT: begin
        if (isJmpS) begin
          pcNextS = jmpTargetS;
        end else begin
          pcNextS = pcR + PC_W'(1'b1);
        end
        if (stopPendR || stop) begin
          nextStateS    = ST_IDLE;
          stopPendNextS = 1'b0;
        end else begin
          nextStateS = ST_FETCH;
        end
      end
      default: begin
        nextStateS = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded purely from registered state so reset clears them at once
  always_comb begin
    imem.imem_req  = 1'b0;
    imem.imem_addr = pcR;
    pc             = pcR;
    instr          = irR;
    instr_valid    = 1'b0;
    commit         = 1'b0;
    busy           = 1'b0;
    halted         = 1'b0;
    case (stateR)
      ST_FETCH: begin
        imem.imem_req = 1'b1;
        busy          = 1'b1;
      end
      ST_EXEC: begin
        instr_valid = 1'b1;
        busy        = 1'b1;
      end
      ST_COMMIT: begin
        instr_valid = 1'b1;
        commit      = !isJmpS;
        busy        = 1'b1;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

`ifdef MIPS_SEQ_RETIRE_CNT_EN
  logic startTakeS;
  assign startTakeS = start && ((stateR == ST_IDLE) || (stateR == ST_HALT));

  mips_seq_retire_ctr u_retireCtr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (startTakeS),
    .inc   (stateR == ST_COMMIT),
    .count (retired)
  );
`endif

endmodule

// File: tb/tb_mips_sequencer.sv
// Directed bench for mips_sequencer: memory model, fetch-address scoreboard and commit accounting.
module tb_mips_sequencer;

  localparam int PC_W        = 12;
  localparam int EXEC_CYCLES = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            stop = 1'b0;
  logic [PC_W-1:0] boot_pc = 12'h000;
  logic [15:0]     instr;
  logic            instr_valid;
  logic            commit;
  logic [PC_W-1:0] pc;
  logic            busy;
  logic            halted;
`ifdef MIPS_SEQ_RETIRE_CNT_EN
  logic [31:0]     retired;
`endif

  mips_seq_if #(.PC_W(PC_W)) mif ();

  mips_sequencer #(.PC_W(PC_W), .EXEC_CYCLES(EXEC_CYCLES)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .boot_pc     (boot_pc),
    .stop        (stop),
    .imem        (mif),
    .instr       (instr),
    .instr_valid (instr_valid),
    .commit      (commit),
    .pc          (pc),
    .busy        (busy),
    .halted      (halted)
`ifdef MIPS_SEQ_RETIRE_CNT_EN
    ,
    .retired     (retired)
`endif
  );

  always #5 clk = ~clk;

  int              checks = 0;
  int              failures = 0;
  logic [15:0]     mem [4096];
  logic [PC_W-1:0] expAddrQ [$];
  int              ackDelay = 0;
  int              waitLeft = 0;
  bit              fetchActive = 1'b0;
  int              reqCycles = 0;
  int              cycle = 0;
  int              lastCommitCycle = -1;
  int              expSpacing = 4;
  bit              checkSpacing = 1'b1;
  int              commitCnt = 0;
  int              expCommitCnt = 0;
  logic [31:0]     expRetired = 32'd0;
  logic [15:0]     prevInstr = 16'h0000;
  bit              lastAcked = 1'b0;
  int              c0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe DUT, account commits, answer fetches from the memory model
  task automatic tick();
    logic [PC_W-1:0] a;
    logic [15:0]     w;
    logic [PC_W-1:0] e;
    bit              ackNow;
    @(posedge clk);
    #1;
    cycle++;
    ackNow = 1'b0;
    if (busy && !lastAcked) chk("instr_hold", 32'(instr), 32'(prevInstr));
    if (commit) begin
      chk("commit_valid", 32'(instr_valid), 32'd1);
      if (checkSpacing && lastCommitCycle >= 0)
        chk("commit_spacing", 32'(cycle - lastCommitCycle), 32'(expSpacing));
      lastCommitCycle = cycle;
      commitCnt++;
    end
    if (instr_valid && instr == 16'hE020) chk("jmp_no_commit", 32'(commit), 32'd0);
    if (mif.imem_req && !fetchActive) begin
      fetchActive = 1'b1;
      waitLeft    = ackDelay;
      reqCycles   = 0;
      chk("sb_nonempty", 32'(expAddrQ.size() > 0), 32'd1);
      if (expAddrQ.size() > 0) begin
        e = expAddrQ.pop_front();
        chk("fetch_addr", 32'(mif.imem_addr), 32'(e));
      end
    end
    if (fetchActive) begin
      reqCycles++;
      if (waitLeft == 0) begin
        a = mif.imem_addr;
        w = mem[a];
        mif.imem_ack   = 1'b1;
        mif.imem_rdata = w;
        ackNow         = 1'b1;
        fetchActive    = 1'b0;
        chk("req_len", 32'(reqCycles), 32'(ackDelay + 1));
        if (w[15:12] != 4'hF) begin
          expRetired = expRetired + 32'd1;
          if (w[15:12] == 4'hE) begin
            expAddrQ.push_back(w[11:0]);
          end else begin
            expCommitCnt++;
            expAddrQ.push_back(a + 12'd1);
          end
        end
      end else begin
        mif.imem_ack   = 1'b0;
        mif.imem_rdata = 16'h5A5A;
        waitLeft--;
      end
    end else begin
      mif.imem_ack   = 1'b0;
      mif.imem_rdata = 16'h5A5A;
    end
    prevInstr = instr;
    lastAcked = ackNow;
  endtask

  task automatic checkZero(input string t);
    chk({t, "_req"}, 32'(mif.imem_req), 32'd0);
    chk({t, "_addr"}, 32'(mif.imem_addr), 32'd0);
    chk({t, "_instr"}, 32'(instr), 32'd0);
    chk({t, "_valid"}, 32'(instr_valid), 32'd0);
    chk({t, "_commit"}, 32'(commit), 32'd0);
    chk({t, "_pc"}, 32'(pc), 32'd0);
    chk({t, "_busy"}, 32'(busy), 32'd0);
    chk({t, "_halted"}, 32'(halted), 32'd0);
`ifdef MIPS_SEQ_RETIRE_CNT_EN
    chk({t, "_retired"}, retired, 32'd0);
`endif
  endtask

  task automatic applyReset(input string t);
    rst_n = 1'b0;
    #1;
    checkZero(t);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fetchActive = 1'b0;
    expAddrQ.delete();
    commitCnt = 0;
    expCommitCnt = 0;
    expRetired = 32'd0;
    lastAcked = 1'b0;
    prevInstr = 16'h0000;
    lastCommitCycle = -1;
    mif.imem_ack = 1'b0;
  endtask

  task automatic doStart(input logic [PC_W-1:0] addr, input logic withStop);
    boot_pc = addr;
    start   = 1'b1;
    stop    = withStop;
    expAddrQ.delete();
    expAddrQ.push_back(addr);
    lastCommitCycle = -1;
    expRetired = 32'd0;
    tick();
    start = 1'b0;
    stop  = 1'b0;
  endtask

  // kind: 0 = EXEC without commit, 1 = commit, 2 = halted
  task automatic waitFor(input int kind, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      case (kind)
        0: seen = instr_valid && !commit;
        1: seen = commit;
        default: seen = halted;
      endcase
      if (!seen) tick();
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic checkCounts(input string t);
    chk({t, "_commits"}, 32'(commitCnt), 32'(expCommitCnt));
`ifdef MIPS_SEQ_RETIRE_CNT_EN
    chk({t, "_retired"}, retired, expRetired);
`endif
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h1000 | 16'(i);
    mif.imem_ack   = 1'b0;
    mif.imem_rdata = 16'h0000;

    applyReset("rst0");
    tick();
    tick();
    checkZero("idle");

    // Zero-wait run from 5, then stop during EXEC
    ackDelay = 0;
    expSpacing = 4;
    doStart(12'h005, 1'b0);
    repeat (12) tick();
    chk("busy_run", 32'(busy), 32'd1);
    waitFor(0, "wait_exec_a");
    c0 = commitCnt;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    waitFor(1, "wait_commit_a");
    tick();
    chk("stop_exec_one_commit", 32'(commitCnt - c0), 32'd1);
    chk("stop_exec_busy", 32'(busy), 32'd0);
    chk("stop_exec_req", 32'(mif.imem_req), 32'd0);
    repeat (3) tick();
    chk("idle_stays", 32'(busy), 32'd0);
    checkCounts("run_a");

    // Three wait states; start and stop together, then stop during FETCH
    ackDelay = 3;
    expSpacing = 7;
    doStart(12'h040, 1'b1);
    waitFor(1, "wait_commit_b1");
    tick();
    chk("start_beats_stop_busy", 32'(busy), 32'd1);
    chk("start_beats_stop_req", 32'(mif.imem_req), 32'd1);
    c0 = commitCnt;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_fetch_still_busy", 32'(busy), 32'd1);
    waitFor(1, "wait_commit_b2");
    tick();
    chk("stop_fetch_one_commit", 32'(commitCnt - c0), 32'd1);
    chk("stop_fetch_busy", 32'(busy), 32'd0);
    checkCounts("run_b");

    // JMP at 3 to 0x020, HALT at 0x021
    ackDelay = 0;
    checkSpacing = 1'b0;
    mem[3] = 16'hE020;
    mem[12'h021] = 16'hF000;
    doStart(12'h001, 1'b0);
    waitFor(2, "wait_halt");
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_busy", 32'(busy), 32'd0);
    chk("halt_commit", 32'(commit), 32'd0);
    chk("halt_pc", 32'(pc), 32'h021);
    chk("halt_instr", 32'(instr), 32'hF000);
    repeat (3) tick();
    chk("halt_pc_frozen", 32'(pc), 32'h021);
    chk("halt_req", 32'(mif.imem_req), 32'd0);
    checkCounts("run_c");

    // Restart from HALT at 0, then reset in the middle of EXEC
    checkSpacing = 1'b1;
    expSpacing = 4;
    doStart(12'h000, 1'b0);
    chk("restart_halted", 32'(halted), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    waitFor(1, "wait_commit_d1");
    tick();
    waitFor(1, "wait_commit_d2");
    tick();
    waitFor(0, "wait_exec_d");
    chk("pre_rst_pc", 32'(pc), 32'h002);
    chk("pre_rst_instr", 32'(instr), 32'h1002);
    applyReset("rst_exec");

    // PC wrap: 0xFFF followed by fetch from 0x000 (HALT there)
    mem[0] = 16'hF000;
    doStart(12'hFFF, 1'b0);
    waitFor(2, "wait_halt_wrap");
    chk("wrap_pc", 32'(pc), 32'h000);
    chk("wrap_halted", 32'(halted), 32'd1);
    checkCounts("run_e");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
